// File: rtl/fb_rect_writer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fb_rect_writer_if
// Description : Command handshake and framebuffer write-port bundle for the
//               rectangle-fill engine.
// Revision    : 1.0  initial release
// ============================================================================
interface fb_rect_writer_if #(
  parameter int COLOR_W = 15
);
  // Command side
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_clear;
  logic [6:0]         cmd_x;
  logic [5:0]         cmd_y;
  logic [7:0]         cmd_w;
  logic [6:0]         cmd_h;
  logic [COLOR_W-1:0] cmd_color;

  // Framebuffer write port and status
  logic [12:0]        mem_waddr;
  logic [COLOR_W-1:0] mem_wdata;
  logic               mem_web;
  logic               busy;
  logic               done;

  // Command source (game / CPU logic)
  modport master (
    output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, mem_waddr, mem_wdata, mem_web, busy, done
  );

  // Rectangle writer
  modport slave (
    input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, mem_waddr, mem_wdata, mem_web, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/fb_rect_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fb_rect_writer
// Description : Clipped rectangle-fill / clear-screen engine. Writes one pixel
//               per clock into the framebuffer in raster order.
// Revision    : 1.0  initial release
// ============================================================================
module fb_rect_writer #(
  parameter int FB_W    = 128,
  parameter int FB_H    = 64,
  parameter int COLOR_W = 15
) (
  input  logic            clk,
  input  logic            rst,
  fb_rect_writer_if.slave bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_FILL = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [7:0] c_FB_W8 = 8'(FB_W);
  localparam logic [7:0] c_FB_H8 = 8'(FB_H);

  logic [1:0]         r_state;
  logic               r_cmd_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_mem_web;
  logic [12:0]        r_mem_waddr;
  logic [COLOR_W-1:0] r_mem_wdata;   // doubles as the latched fill colour
  logic [6:0]         r_x0;
  logic [6:0]         r_x_last;
  logic [5:0]         r_y_last;
  logic [6:0]         r_cx;
  logic [5:0]         r_cy;

  logic [7:0] w_x_room;
  logic [7:0] w_y_room;
  logic [7:0] w_h8;
  logic [7:0] w_ew;
  logic [7:0] w_eh;
  logic [6:0] w_x0;
  logic [5:0] w_y0;
  logic [6:0] w_x_last;
  logic [5:0] w_y_last;
  logic       w_empty;
  logic       w_accept;
  logic       w_row_end;
  logic       w_last;
  logic [6:0] w_cx_next;
  logic [5:0] w_cy_next;

  // Clip the requested size against the screen edges and derive the last pixel
  always_comb begin
    w_x_room = c_FB_W8 - {1'b0, bus.cmd_x};
    w_y_room = c_FB_H8 - {2'b0, bus.cmd_y};
    w_h8     = {1'b0, bus.cmd_h};
    if (bus.cmd_clear) begin
      w_x0 = 7'd0;
      w_y0 = 6'd0;
      w_ew = c_FB_W8;
      w_eh = c_FB_H8;
    end else begin
      w_x0 = bus.cmd_x;
      w_y0 = bus.cmd_y;
      w_ew = (bus.cmd_w < w_x_room) ? bus.cmd_w : w_x_room;
      w_eh = (w_h8 < w_y_room) ? w_h8 : w_y_room;
    end
    // Modular arithmetic is exact here: x0+ew-1 <= 127 and y0+eh-1 <= 63
    w_x_last  = w_x0 + w_ew[6:0] - 7'd1;
    w_y_last  = w_y0 + w_eh[5:0] - 6'd1;
    w_empty   = (w_ew == 8'd0) || (w_eh == 8'd0);
    w_accept  = bus.cmd_valid && r_cmd_ready && (r_state == c_IDLE);
    w_row_end = (r_cx == r_x_last);
    w_last    = w_row_end && (r_cy == r_y_last);
    w_cx_next = r_cx + 7'd1;
    w_cy_next = r_cy + 6'd1;
  end

  // Command FSM and raster walker; the pixel on the write port is (r_cx, r_cy)
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= c_IDLE;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_web   <= 1'b0;
      r_mem_waddr <= 13'd0;
      r_mem_wdata <= '0;
      r_x0        <= 7'd0;
      r_x_last    <= 7'd0;
      r_y_last    <= 6'd0;
      r_cx        <= 7'd0;
      r_cy        <= 6'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_mem_wdata <= bus.cmd_color;
            r_x0        <= w_x0;
            r_x_last    <= w_x_last;
            r_y_last    <= w_y_last;
            r_cx        <= w_x0;
            r_cy        <= w_y0;
            if (w_empty) begin
              r_done  <= 1'b1;
              r_state <= c_DONE;
            end else begin
              // First pixel goes out straight from the accept edge
              r_mem_web   <= 1'b1;
              r_mem_waddr <= {w_y0, w_x0};
              r_state     <= c_FILL;
            end
          end
        end
        c_FILL: begin
          if (w_last) begin
            r_mem_web <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= c_DONE;
          end else if (w_row_end) begin
            r_cx        <= r_x0;
            r_cy        <= w_cy_next;
            r_mem_waddr <= {w_cy_next, r_x0};
          end else begin
            r_cx        <= w_cx_next;
            r_mem_waddr <= {r_cy, w_cx_next};
          end
        end
        c_DONE: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= c_IDLE;
        end
        default: begin
          r_state     <= c_IDLE;
          r_mem_web   <= 1'b0;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.mem_web   = r_mem_web;
  assign bus.mem_waddr = r_mem_waddr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_fb_rect_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fb_rect_writer
// Description : Self-checking bench for fb_rect_writer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fb_rect_writer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_rect_writer_if bus ();

  fb_rect_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        clr;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [7:0]  w;
    logic [6:0]  h;
    logic [14:0] color;
    int          ew;
    int          eh;
    logic [12:0] first;
    logic [12:0] last;
  } vec_t;

  vec_t vecs [8];
  bit   sb   [0:8191];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic wait_ready(input string tag);
    int cyc = 0;
    while (bus.cmd_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_ready_wait"}, 32'(cyc < 20), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n, x0, y0, idx;
    int web_err = 0, addr_err = 0, data_err = 0, done_err = 0;
    int busy_err = 0, ready_err = 0, dup = 0, nset = 0;
    logic [12:0] exp_a, first_a, last_a;
    bit got_first = 0;
    n  = v.ew * v.eh;
    x0 = v.clr ? 0 : int'(v.x);
    y0 = v.clr ? 0 : int'(v.y);
    first_a = '0;
    last_a  = '0;
    wait_ready(tag);
    for (int i = 0; i < 8192; i++) sb[i] = 1'b0;
    bus.cmd_clear = v.clr; bus.cmd_x = v.x; bus.cmd_y = v.y;
    bus.cmd_w = v.w; bus.cmd_h = v.h; bus.cmd_color = v.color;
    bus.cmd_valid = 1'b1;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Later input changes must not disturb the command in flight
        bus.cmd_valid = 1'b0;
        bus.cmd_clear = ~v.clr; bus.cmd_x = ~v.x; bus.cmd_y = ~v.y;
        bus.cmd_w = ~v.w; bus.cmd_h = ~v.h; bus.cmd_color = ~v.color;
      end
      if (bus.mem_web !== 1'(k <= n))      web_err++;
      if (bus.done    !== 1'(k == n + 1))  done_err++;
      if (bus.busy    !== 1'(k <= n + 1))  busy_err++;
      if (bus.cmd_ready !== 1'(k == n + 2)) ready_err++;
      if (k <= n && bus.mem_web === 1'b1) begin
        idx   = k - 1;
        exp_a = 13'((y0 + idx / v.ew) * 128 + x0 + idx % v.ew);
        if (bus.mem_waddr !== exp_a)   addr_err++;
        if (bus.mem_wdata !== v.color) data_err++;
        if (sb[bus.mem_waddr]) dup++;
        else nset++;
        sb[bus.mem_waddr] = 1'b1;
        if (!got_first) first_a = bus.mem_waddr;
        got_first = 1;
        last_a = bus.mem_waddr;
      end
    end
    check({tag, "_web_seq"},   web_err,   0);
    check({tag, "_addr_seq"},  addr_err,  0);
    check({tag, "_data"},      data_err,  0);
    check({tag, "_done"},      done_err,  0);
    check({tag, "_busy"},      busy_err,  0);
    check({tag, "_ready"},     ready_err, 0);
    check({tag, "_sb_unique"}, nset,      n);
    check({tag, "_sb_dup"},    dup,       0);
    if (n > 0) begin
      check({tag, "_first_addr"}, first_a, v.first);
      check({tag, "_last_addr"},  last_a,  v.last);
    end
  endtask

  initial begin
    int err;
    int na;
    logic [7:0]  web_pat, done_pat;
    logic [12:0] addrs [5];
    logic [14:0] bdata;

    //            clr   x       y      w       h       colour    ew   eh  first     last
    vecs[0] = '{1'b0, 7'd10,  6'd5,  8'd3,   7'd2,   15'h7C00, 3,   2,  13'h28A,  13'h30C};
    vecs[1] = '{1'b0, 7'd126, 6'd63, 8'd5,   7'd4,   15'h001F, 2,   1,  13'h1FFE, 13'h1FFF};
    vecs[2] = '{1'b0, 7'd3,   6'd3,  8'd0,   7'd10,  15'h03E0, 0,   10, 13'h0,    13'h0};
    vecs[3] = '{1'b0, 7'd3,   6'd3,  8'd10,  7'd0,   15'h03E0, 10,  0,  13'h0,    13'h0};
    vecs[4] = '{1'b0, 7'd0,   6'd0,  8'd1,   7'd1,   15'h001F, 1,   1,  13'h0,    13'h0};
    vecs[5] = '{1'b0, 7'd0,   6'd10, 8'd255, 7'd1,   15'h03E0, 128, 1,  13'h500,  13'h57F};
    vecs[6] = '{1'b0, 7'd120, 6'd60, 8'd8,   7'd127, 15'h2A5A, 8,   4,  13'h1E78, 13'h1FFF};
    vecs[7] = '{1'b1, 7'd50,  6'd30, 8'd2,   7'd2,   15'h7FFF, 128, 64, 13'h0,    13'h1FFF};

    rst = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_clear = 1'b0; bus.cmd_x = '0; bus.cmd_y = '0;
    bus.cmd_w = '0; bus.cmd_h = '0; bus.cmd_color = '0;

    // Reset held for 5 cycles: no writes, no status
    err = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.mem_web !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) err++;
    end
    check("reset_quiet", err, 0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_ready", bus.cmd_ready, 1);
    check("reset_web",   bus.mem_web,   0);
    check("reset_waddr", bus.mem_waddr, 0);
    check("reset_wdata", bus.mem_wdata, 0);
    check("reset_busy",  bus.busy,      0);
    check("reset_done",  bus.done,      0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Second command held valid while the first is running
    wait_ready("b2b");
    bus.cmd_clear = 1'b0; bus.cmd_x = 7'd0; bus.cmd_y = 6'd0;
    bus.cmd_w = 8'd2; bus.cmd_h = 7'd1; bus.cmd_color = 15'h1234;
    bus.cmd_valid = 1'b1;
    web_pat = '0; done_pat = '0; na = 0; bdata = '0;
    for (int i = 0; i < 5; i++) addrs[i] = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      web_pat[k-1]  = bus.mem_web;
      done_pat[k-1] = bus.done;
      if (bus.mem_web === 1'b1 && na < 5) begin
        addrs[na] = bus.mem_waddr;
        if (na == 4) bdata = bus.mem_wdata;
        na++;
      end
      if (k == 1) begin
        bus.cmd_x = 7'd5; bus.cmd_y = 6'd1; bus.cmd_w = 8'd3; bus.cmd_color = 15'h0ABC;
      end
      if (k == 5) bus.cmd_valid = 1'b0;
    end
    check("b2b_web_pattern",  web_pat,  8'h73);
    check("b2b_done_pattern", done_pat, 8'h84);
    check("b2b_writes",       na,       5);
    check("b2b_addr0", addrs[0], 13'd0);
    check("b2b_addr1", addrs[1], 13'd1);
    check("b2b_addr2", addrs[2], 13'd133);
    check("b2b_addr3", addrs[3], 13'd134);
    check("b2b_addr4", addrs[4], 13'd135);
    check("b2b_data",  bdata,    15'h0ABC);

    // Reset dropped in the middle of a fill
    wait_ready("abort");
    bus.cmd_clear = 1'b0; bus.cmd_x = 7'd0; bus.cmd_y = 6'd2;
    bus.cmd_w = 8'd10; bus.cmd_h = 7'd2; bus.cmd_color = 15'h5555;
    bus.cmd_valid = 1'b1;
    na = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.mem_web === 1'b1) na++;
    end
    check("abort_writes_before", na, 4);
    rst = 1'b0;
    @(negedge clk);
    check("abort_web",  bus.mem_web, 0);
    check("abort_done", bus.done,    0);
    check("abort_busy", bus.busy,    0);
    @(negedge clk);
    err = (bus.done !== 1'b0 || bus.mem_web !== 1'b0) ? 1 : 0;
    rst = 1'b1;
    @(negedge clk);
    if (bus.done !== 1'b0) err++;
    check("abort_no_done", err,           0);
    check("abort_ready",   bus.cmd_ready, 1);
    check("abort_idle_web", bus.mem_web,  0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_rect_writer.md
# fb_rect_writer

Framebuffer write-side engine for the VGA display path. Accepts rectangle-fill and clear-screen commands over a valid/ready handshake and drives the display interface's framebuffer write port (`mem_waddr`/`mem_wdata`/`mem_web`) one pixel per clock. It sits between game or CPU logic (e.g. the pong demo) and the display interface, which scans the same framebuffer out to VGA.

## Interface

Parameters
- `FB_W`, 128: framebuffer width in pixels. Fixed; the x field is 7 bits.
- `FB_H`, 64: framebuffer height in pixels. Fixed; the y field is 6 bits.
- `COLOR_W`, 15: pixel width, RGB555 as `{R[14:10], G[9:5], B[4:0]}`.

Ports
- `clk` in 1: single system clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-low. 0 = reset.
- `cmd_valid` in 1: a command is present.
- `cmd_ready` out 1: the block can accept a command.
- `cmd_clear` in 1: 1 = clear the whole screen; `cmd_x`, `cmd_y`, `cmd_w` and `cmd_h` are ignored.
- `cmd_x` in 7: left column, 0..127.
- `cmd_y` in 6: top row, 0..63.
- `cmd_w` in 8: width in pixels, 0..255.
- `cmd_h` in 7: height in pixels, 0..127.
- `cmd_color` in 15: fill colour.
- `mem_waddr` out 13: framebuffer address, `{y[5:0], x[6:0]}`.
- `mem_wdata` out 15: pixel data.
- `mem_web` out 1: write strobe, active-high. One pixel is written per cycle while it is 1.
- `busy` out 1: 1 from command accept until `done`.
- `done` out 1: one-cycle pulse when a command completes.

## Operation

- **FSM states:** IDLE, FILL, DONE.
- **IDLE:**
  - `cmd_ready` = 1.
  - A command is accepted on `cmd_valid & cmd_ready`.
  - On accept, register the colour and the origin.
  - Compute the effective size:
    - `ew = min(cmd_w, 128 - cmd_x)`.
    - `eh = min(cmd_h, 64 - cmd_y)`.
    - Use 8-bit arithmetic; no wrap-around.
  - A clear command forces origin (0,0), `ew` = 128, `eh` = 64.
  - If `ew == 0` or `eh == 0`: go to DONE with no writes. Otherwise go to FILL.
- **FILL:**
  - Every cycle, `mem_web` = 1 with `mem_waddr = {cy, cx}` and `mem_wdata` = colour.
  - Raster order: `cx` is the inner loop, `cy` the outer.
  - At the end of a row (`cx == x0 + ew - 1`): `cx` ← `x0`, `cy` += 1.
  - After pixel (`x0 + ew - 1`, `y0 + eh - 1`): go to DONE.
  - `cmd_ready` = 0 in FILL.
- **DONE:**
  - `done` = 1 for one cycle.
  - `cmd_ready` = 0.
  - Next state is IDLE.
- **Clipping:** no write ever leaves the rectangle or crosses a row or screen edge. Addresses stay within 0..8191, and `cx` never wraps into the next row.
- **Input stability:** command fields are sampled only on the accept cycle. Later changes on the inputs have no effect on the command in progress.
- **Reset:**
  - Reset in any state (including mid-FILL) returns to IDLE on the next edge and abandons the remaining pixels.
  - Pixels already written stay written.
  - No `done` pulse is issued for the abandoned command.

## Timing

- **Reset values:**
  - `cmd_ready` = 1 from the first edge after reset releases.
  - `mem_web` = 0, `mem_waddr` = 0, `mem_wdata` = 0.
  - `busy` = 0, `done` = 0.
- **Outputs:** all outputs are registered. `mem_*` change only on `clk` edges.
- **Write schedule:**
  - Accept at edge T.
  - First write is visible in cycle T+1.
  - Write *n* is in cycle T+*n*.
  - `mem_web` is continuous, with no bubbles, for `ew*eh` cycles.
- **Completion:**
  - `done` is high in the cycle after the last write.
  - `cmd_ready` returns to 1 the cycle after `done`.
  - Back-to-back throughput: `ew*eh + 2` cycles per command.
- **Degenerate command** (`ew` or `eh` = 0): `done` is in cycle T+1, with zero writes.
- **`busy`:** = 1 in cycles T+1 through the `done` cycle inclusive.
- **Handshake:** `cmd_valid` held high while `cmd_ready` = 0 is not accepted. The command is accepted once the block returns to IDLE.
- **Full clear:** 8192 writes, `done` at T+8193.

## Test plan

- **Reset behaviour:** hold `rst` = 0 for 5 cycles → `mem_web` = 0, `busy` = 0 and `done` = 0 throughout; `cmd_ready` = 1 after release.
- **Basic rectangle:** x=10, y=5, w=3, h=2, colour 0x7C00 → 6 writes, one per cycle and contiguous.
  - Address order: 0x28A, 0x28B, 0x28C, 0x30A, 0x30B, 0x30C.
  - Data is 0x7C00 on all six writes.
  - `done` pulses in the cycle after the last write.
- **Clipping:** x=126, y=63, w=5, h=4 → exactly 2 writes, to 0x1FFE and 0x1FFF. No address wrap.
- **Zero size:** w=0, h=10 → no `mem_web` pulse; `done` in cycle T+1. Repeat with h=0 and w=10 for the same result.
- **Clear screen:** `cmd_clear` = 1, colour 0x7FFF → 8192 consecutive writes.
  - Addresses run 0..8191 in order.
  - `done` at T+8193.
  - Scoreboard check: every address written exactly once.
- **Handshake and reset abort:**
  - Assert a second command while busy → it is accepted only after the first command's `done`, with exactly 2 idle cycles between the two write bursts.
  - Separately, drop `rst` mid-FILL → `mem_web` = 0 on the next cycle, no `done`, and `cmd_ready` = 1 after release.
